// File: rtl/dmem_copy_engine.sv
// Word-granular memory-to-memory copy engine with overlap-safe direction selection.
// One read per cycle; each word is written one cycle after it is read.
module dmem_copy_engine #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      r_addr,
    output logic             re,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      wr_addr,
    output logic [31:0]      data_in,
    output logic             we
);

    localparam int unsigned AW  = 32;
    localparam int unsigned EW  = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_left_q, rd_left_d;
    logic             desc_q, desc_d;
    logic             re_q, re_d;
    logic [AW-1:0]    r_addr_q, r_addr_d;
    logic             we_q, we_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [EW-1:0]    src_end_c;
    logic [EW-1:0]    dst_end_c;
    logic             req_bad_c;
    logic             req_desc_c;
    logic [AW-1:0]    len_m1_c;
    logic [AW-1:0]    rd_start_c;
    logic [AW-1:0]    wr_start_c;

    // Request qualification in 33-bit arithmetic so src+len cannot wrap.
    assign src_end_c  = {1'b0, src} + EW'(len);
    assign dst_end_c  = {1'b0, dst} + EW'(len);
    assign req_bad_c  = (len == '0) || (src_end_c > EW'(DEPTH)) || (dst_end_c > EW'(DEPTH));
    // Descend only when dst lands inside the source window above src.
    assign req_desc_c = ({1'b0, src} < {1'b0, dst}) && ({1'b0, dst} < src_end_c);
    assign len_m1_c   = AW'(len) - AW'(1);
    assign rd_start_c = req_desc_c ? (src + len_m1_c) : src;
    assign wr_start_c = req_desc_c ? (dst + len_m1_c) : dst;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_left_d = rd_left_q;
        desc_d    = desc_q;
        re_d      = 1'b0;
        r_addr_d  = '0;
        // A read issued this cycle becomes the write of the next cycle.
        we_d      = re_q;
        wr_addr_d = re_q ? wr_ptr_q : '0;
        hold_d    = re_q ? mem_rdata : '0;
        if (re_q) begin
            wr_ptr_d = desc_q ? (wr_ptr_q - AW'(1)) : (wr_ptr_q + AW'(1));
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_bad_c) begin
                        state_d = S_ERR;
                    end else begin
                        state_d   = S_COPY;
                        desc_d    = req_desc_c;
                        re_d      = 1'b1;
                        r_addr_d  = rd_start_c;
                        rd_ptr_d  = req_desc_c ? (rd_start_c - AW'(1)) : (rd_start_c + AW'(1));
                        wr_ptr_d  = wr_start_c;
                        rd_left_d = len - LEN_W'(1);
                    end
                end
            end
            S_COPY: begin
                if (rd_left_q != '0) begin
                    re_d      = 1'b1;
                    r_addr_d  = rd_ptr_q;
                    rd_ptr_d  = desc_q ? (rd_ptr_q - AW'(1)) : (rd_ptr_q + AW'(1));
                    rd_left_d = rd_left_q - LEN_W'(1);
                end
                // Last write is on the bus with no read behind it.
                if (we_q && !re_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_COPY);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_left_q <= '0;
            desc_q    <= 1'b0;
            re_q      <= 1'b0;
            r_addr_q  <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_left_q <= rd_left_d;
            desc_q    <= desc_d;
            re_q      <= re_d;
            r_addr_q  <= r_addr_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign re      = re_q;
    assign r_addr  = r_addr_q;
    assign we      = we_q;
    assign wr_addr = wr_addr_q;
    assign data_in = hold_q;

endmodule
